obstacle_gen_multi: RTL and testbench



---
 rtl/obstacle_gen_multi_if.sv | 27 ++
 rtl/obstacle_gen_multi.sv | 174 +++++++++++++++++
 tb/tb_obstacle_gen_multi.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_gen_multi_if.sv
// Control and render-facing signals of the obstacle field generator.
// The generator sits on the slave side; the game logic and renderer sit on the master side.
interface obstacle_gen_multi_if #(
    parameter int unsigned NUM_OBST = 10,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 9,
    parameter int unsigned SPD_W    = 3
);
    logic                                  frame_tick;
    logic                                  run;
    logic [SPD_W-1:0]                      speed;
    logic [NUM_OBST-1:0][2*XW-1:0]         obstacle_x;
    logic [NUM_OBST-1:0][2*YW-1:0]         obstacle_y;
    logic [NUM_OBST-1:0]                   obstacle_valid;
    logic [$clog2(NUM_OBST+1)-1:0]         active_count;
    logic                                  spawn;

    modport master (
        output frame_tick, run, speed,
        input  obstacle_x, obstacle_y, obstacle_valid, active_count, spawn
    );

    modport slave (
        input  frame_tick, run, speed,
        output obstacle_x, obstacle_y, obstacle_valid, active_count, spawn
    );
endinterface

// File: rtl/obstacle_gen_multi.sv
// Slot-table obstacle field: scrolls left once per frame step, spawns LFSR-sized obstacles
// at the right edge and presents clipped rectangles to the renderer.
module obstacle_gen_multi #(
    parameter int unsigned NUM_OBST = 10,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 9,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned TOP      = 20,
    parameter int unsigned BOTTOM   = 440,
    parameter int unsigned MIN_W    = 20,
    parameter int unsigned MAX_W    = 80,
    parameter int unsigned MIN_H    = 20,
    parameter int unsigned MAX_H    = 150,
    parameter int unsigned MIN_GAP  = 120,
    parameter int unsigned MAX_GAP  = 250,
    parameter int unsigned SPD_W    = 3,
    parameter logic [31:0] SEED     = 32'h12345678,
    parameter int unsigned OFF_X    = 700,
    parameter int unsigned OFF_Y    = 500
) (
    input logic                 clk,
    input logic                 rst,
    obstacle_gen_multi_if.slave bus
);
    localparam int unsigned PW     = XW + 2;
    localparam int unsigned IW     = $clog2(NUM_OBST);
    localparam int unsigned CW     = $clog2(NUM_OBST + 1);
    localparam int unsigned W_SPAN = MAX_W - MIN_W + 1;
    localparam int unsigned H_SPAN = MAX_H - MIN_H + 1;
    localparam int unsigned G_SPAN = MAX_GAP - MIN_GAP + 1;

    typedef logic signed [PW-1:0] pos_t;

    localparam pos_t SCR  = pos_t'(SCREEN_W);
    localparam pos_t ZERO = pos_t'(0);

    logic [NUM_OBST-1:0] active_q, active_d;
    pos_t                pos_x_q [NUM_OBST];
    pos_t                pos_x_d [NUM_OBST];
    logic [YW-1:0]       pos_y_q [NUM_OBST];
    logic [YW-1:0]       pos_y_d [NUM_OBST];
    logic [6:0]          w_q     [NUM_OBST];
    logic [6:0]          w_d     [NUM_OBST];
    logic [7:0]          h_q     [NUM_OBST];
    logic [7:0]          h_d     [NUM_OBST];
    logic [8:0]          gap_cnt_q, gap_cnt_d;
    logic [31:0]         lfsr_q, lfsr_d;
    logic                spawn_q, spawn_d;

    logic [6:0]          new_w;
    logic [7:0]          new_h;
    logic [8:0]          new_gap;
    logic [9:0]          y_span;
    logic [YW-1:0]       new_y;
    logic                free_found;
    logic [IW-1:0]       free_idx;

    // Scaled byte fields: byte*span>>8 maps 0..255 onto 0..span-1 inclusive of both ends.
    always_comb begin
        new_w   = 7'(MIN_W) + 7'((18'(lfsr_q[7:0]) * 18'(W_SPAN)) >> 8);
        new_h   = 8'(MIN_H) + 8'((18'(lfsr_q[15:8]) * 18'(H_SPAN)) >> 8);
        new_gap = 9'(MIN_GAP) + 9'((18'(lfsr_q[23:16]) * 18'(G_SPAN)) >> 8);
        y_span  = 10'(BOTTOM - TOP + 1) - 10'(new_h);
        new_y   = YW'(TOP) + YW'((18'(lfsr_q[31:24]) * 18'(y_span)) >> 8);
    end

    // Lowest-index free slot, judged on the pre-step mask so same-step retirees are not reused.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int k = NUM_OBST - 1; k >= 0; k--) begin
            if (!active_q[k]) begin
                free_found = 1'b1;
                free_idx   = IW'(k);
            end
        end
    end

    always_comb begin
        pos_t moved;
        moved     = ZERO;
        active_d  = active_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        w_d       = w_q;
        h_d       = h_q;
        gap_cnt_d = gap_cnt_q;
        spawn_d   = 1'b0;
        lfsr_d    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

        if (bus.frame_tick && bus.run) begin
            for (int k = 0; k < NUM_OBST; k++) begin
                if (active_q[k]) begin
                    moved      = pos_x_q[k] - pos_t'(bus.speed);
                    pos_x_d[k] = moved;
                    if (moved + pos_t'(w_q[k]) <= ZERO) begin
                        active_d[k] = 1'b0;
                    end
                end
            end

            gap_cnt_d = (gap_cnt_q > 9'(bus.speed)) ? gap_cnt_q - 9'(bus.speed) : '0;

            // With no free slot the counter rests at zero, so the spawn fires on a later step.
            if (gap_cnt_d == '0 && free_found) begin
                active_d[free_idx] = 1'b1;
                pos_x_d[free_idx]  = SCR;
                pos_y_d[free_idx]  = new_y;
                w_d[free_idx]      = new_w;
                h_d[free_idx]      = new_h;
                gap_cnt_d          = 9'(new_w) + new_gap;
                spawn_d            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= '0;
            gap_cnt_q <= 9'(MIN_GAP);
            lfsr_q    <= SEED;
            spawn_q   <= 1'b0;
            for (int k = 0; k < NUM_OBST; k++) begin
                pos_x_q[k] <= ZERO;
                pos_y_q[k] <= '0;
                w_q[k]     <= '0;
                h_q[k]     <= '0;
            end
        end else begin
            active_q  <= active_d;
            gap_cnt_q <= gap_cnt_d;
            lfsr_q    <= lfsr_d;
            spawn_q   <= spawn_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            w_q       <= w_d;
            h_q       <= h_d;
        end
    end

    always_comb begin
        pos_t          right_full;
        logic [XW-1:0] left;
        logic [XW-1:0] right;
        right_full         = ZERO;
        left               = '0;
        right              = '0;
        bus.obstacle_valid = '0;
        bus.obstacle_x     = '0;
        bus.obstacle_y     = '0;
        for (int k = 0; k < NUM_OBST; k++) begin
            right_full = pos_x_q[k] + pos_t'(w_q[k]);
            left       = pos_x_q[k][PW-1] ? '0 : pos_x_q[k][XW-1:0];
            right      = (right_full > SCR) ? XW'(SCREEN_W) : right_full[XW-1:0];
            if (active_q[k] && pos_x_q[k] < SCR && right_full > ZERO) begin
                bus.obstacle_valid[k] = 1'b1;
                bus.obstacle_x[k]     = {left, right};
                bus.obstacle_y[k]     = {pos_y_q[k], pos_y_q[k] + YW'(h_q[k])};
            end else begin
                bus.obstacle_x[k] = {XW'(OFF_X), XW'(OFF_X)};
                bus.obstacle_y[k] = {YW'(OFF_Y), YW'(OFF_Y)};
            end
        end
    end

    always_comb begin
        bus.active_count = '0;
        for (int k = 0; k < NUM_OBST; k++) begin
            bus.active_count = bus.active_count + CW'(active_q[k]);
        end
    end

    assign bus.spawn = spawn_q;
endmodule

// File: tb/tb_obstacle_gen_multi.sv
// Directed bench: default field checked against a behavioural model; a 2-slot, zero-gap,
// fixed-width instance checks exhaustion/deferral and left clipping by hand-computed values.
module tb_obstacle_gen_multi;
    typedef logic [9:0][19:0] vx_t;
    typedef logic [9:0][17:0] vy_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    obstacle_gen_multi_if #(.NUM_OBST(10), .XW(10), .YW(9), .SPD_W(3)) bus_a ();
    obstacle_gen_multi_if #(.NUM_OBST(2), .XW(10), .YW(9), .SPD_W(3)) bus_b ();

    obstacle_gen_multi dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    obstacle_gen_multi #(
        .NUM_OBST (2),
        .MIN_GAP  (0),
        .MAX_GAP  (0),
        .MIN_W    (20),
        .MAX_W    (20)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // Behavioural model of the default instance.
    logic [31:0] m_lfsr, m_prev;
    logic [9:0]  m_act;
    int          m_x [10];
    int          m_w [10];
    int          m_h [10];
    int          m_y [10];
    int          m_gap;
    logic        m_spawn;

    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (rst_a) m_lfsr <= 32'h12345678;
        else       m_lfsr <= {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
    end

    task automatic model_reset();
        m_act   = '0;
        m_gap   = 120;
        m_spawn = 1'b0;
        for (int k = 0; k < 10; k++) begin
            m_x[k] = 0; m_w[k] = 0; m_h[k] = 0; m_y[k] = 0;
        end
    endtask

    task automatic model_step(input int spd, input logic [31:0] r);
        logic [9:0] pre;
        int bw, bh, bg, by;
        pre = m_act;
        for (int k = 0; k < 10; k++) begin
            if (m_act[k]) begin
                m_x[k] = m_x[k] - spd;
                if (m_x[k] + m_w[k] <= 0) m_act[k] = 1'b0;
            end
        end
        m_gap   = (m_gap > spd) ? m_gap - spd : 0;
        m_spawn = 1'b0;
        bw = 20 + ((int'(r[7:0]) * 61) >> 8);
        bh = 20 + ((int'(r[15:8]) * 131) >> 8);
        bg = 120 + ((int'(r[23:16]) * 131) >> 8);
        by = 20 + ((int'(r[31:24]) * (421 - bh)) >> 8);
        if (m_gap == 0) begin
            for (int k = 0; k < 10; k++) begin
                if (!pre[k] && !m_spawn) begin
                    m_act[k] = 1'b1;
                    m_x[k]   = 640;
                    m_w[k]   = bw;
                    m_h[k]   = bh;
                    m_y[k]   = by;
                    m_gap    = bw + bg;
                    m_spawn  = 1'b1;
                end
            end
        end
    endtask

    function automatic logic exp_valid(input int k);
        return m_act[k] && m_x[k] < 640 && m_x[k] + m_w[k] > 0;
    endfunction

    function automatic logic [19:0] exp_x(input int k);
        int l, r;
        if (!exp_valid(k)) return {10'd700, 10'd700};
        l = (m_x[k] < 0) ? 0 : m_x[k];
        r = (m_x[k] + m_w[k] > 640) ? 640 : m_x[k] + m_w[k];
        return {10'(l), 10'(r)};
    endfunction

    function automatic logic [17:0] exp_y(input int k);
        if (!exp_valid(k)) return {9'd500, 9'd500};
        return {9'(m_y[k]), 9'(m_y[k] + m_h[k])};
    endfunction

    function automatic logic [9:0] exp_v_all();
        logic [9:0] v;
        for (int k = 0; k < 10; k++) v[k] = exp_valid(k);
        return v;
    endfunction

    function automatic vx_t exp_x_all();
        vx_t v;
        for (int k = 0; k < 10; k++) v[k] = exp_x(k);
        return v;
    endfunction

    function automatic vy_t exp_y_all();
        vy_t v;
        for (int k = 0; k < 10; k++) v[k] = exp_y(k);
        return v;
    endfunction

    // One tick on instance A after (spacing-1) idle cycles; returns in the cycle after the edge.
    task automatic step_a(input int spd, input logic do_run, input int spacing);
        repeat (spacing - 1) @(negedge clk);
        bus_a.speed      = 3'(spd);
        bus_a.run        = do_run;
        bus_a.frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.frame_tick = 1'b0;
        if (do_run) model_step(spd, m_prev);
        else        m_spawn = 1'b0;
    endtask

    task automatic step_b(input int spd);
        bus_b.speed      = 3'(spd);
        bus_b.run        = 1'b1;
        bus_b.frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_b.frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus_a.obstacle_valid !== 10'd0 || bus_a.active_count !== 4'd0 || bus_a.spawn !== 1'b0)
            begin errors++; $display("FAIL reset_flags: valid=%b cnt=%0d spawn=%b want 0/0/0",
                bus_a.obstacle_valid, bus_a.active_count, bus_a.spawn); end
        checks++;
        if (bus_a.obstacle_x !== {10{10'd700, 10'd700}} || bus_a.obstacle_y !== {10{9'd500, 9'd500}})
            begin errors++; $display("FAIL reset_park: x=%h y=%h want all 700/500",
                bus_a.obstacle_x, bus_a.obstacle_y); end
        checks++;
        if (dut_a.lfsr_q !== 32'h12345678 || dut_a.gap_cnt_q !== 9'd120)
            begin errors++; $display("FAIL reset_state: lfsr=%h gap=%0d want 12345678/120",
                dut_a.lfsr_q, dut_a.gap_cnt_q); end
        checks++;
        if (bus_b.obstacle_valid !== 2'd0 || bus_b.active_count !== 2'd0)
            begin errors++; $display("FAIL reset_b: valid=%b cnt=%0d want 0/0",
                bus_b.obstacle_valid, bus_b.active_count); end
        rst_a = 1'b0;
        rst_b = 1'b0;
        model_reset();
    endtask

    task automatic test_first_spawn();
        for (int t = 1; t <= 61; t++) begin
            step_a(2, 1'b1, 8);
            if (t == 59) begin
                checks++;
                if (bus_a.spawn !== 1'b0 || bus_a.active_count !== 4'd0)
                    begin errors++; $display("FAIL first_spawn_t59: spawn=%b cnt=%0d want 0/0",
                        bus_a.spawn, bus_a.active_count); end
            end
            if (t == 60) begin
                checks++;
                if (bus_a.spawn !== 1'b1 || bus_a.obstacle_valid[0] !== 1'b0 ||
                    bus_a.obstacle_x[0] !== {10'd700, 10'd700} || bus_a.active_count !== 4'd1)
                    begin errors++; $display("FAIL first_spawn_t60: spawn=%b v0=%b x0=%h cnt=%0d want 1/0/af2bc/1",
                        bus_a.spawn, bus_a.obstacle_valid[0], bus_a.obstacle_x[0], bus_a.active_count); end
            end
            if (t == 61) begin
                checks++;
                if (bus_a.spawn !== 1'b0 || bus_a.obstacle_valid[0] !== 1'b1 ||
                    bus_a.obstacle_x[0][19:10] !== 10'd638)
                    begin errors++; $display("FAIL first_spawn_t61: spawn=%b v0=%b left=%0d want 0/1/638",
                        bus_a.spawn, bus_a.obstacle_valid[0], bus_a.obstacle_x[0][19:10]); end
                checks++;
                if (bus_a.obstacle_x[0] !== exp_x(0) || bus_a.obstacle_y[0] !== exp_y(0))
                    begin errors++; $display("FAIL first_spawn_fields: x=%h y=%h want x=%h y=%h",
                        bus_a.obstacle_x[0], bus_a.obstacle_y[0], exp_x(0), exp_y(0)); end
            end
        end
    endtask

    task automatic test_field_ranges();
        int nspawn = 0;
        int top, bot;
        for (int t = 0; t < 10000; t++) begin
            step_a(7, 1'b1, 2);
            if (m_spawn) nspawn++;
            checks++;
            if (bus_a.spawn !== m_spawn || bus_a.active_count !== 4'($countones(m_act)))
                begin errors++; $display("FAIL field_ctl t%0d: spawn=%b cnt=%0d want %b/%0d",
                    t, bus_a.spawn, bus_a.active_count, m_spawn, $countones(m_act)); end
            checks++;
            if (bus_a.obstacle_valid !== exp_v_all() || bus_a.obstacle_x !== exp_x_all() ||
                bus_a.obstacle_y !== exp_y_all())
                begin errors++; $display("FAIL field_rects t%0d: v=%b x=%h y=%h want v=%b x=%h y=%h",
                    t, bus_a.obstacle_valid, bus_a.obstacle_x, bus_a.obstacle_y,
                    exp_v_all(), exp_x_all(), exp_y_all()); end
            for (int k = 0; k < 10; k++) begin
                if (bus_a.obstacle_valid[k]) begin
                    top = int'(bus_a.obstacle_y[k][17:9]);
                    bot = int'(bus_a.obstacle_y[k][8:0]);
                    checks++;
                    if (top < 20 || bot > 440 || bot - top < 20 || bot - top > 150)
                        begin errors++; $display("FAIL field_yrange t%0d slot%0d: top=%0d bot=%0d want 20<=top, bot<=440, h 20..150",
                            t, k, top, bot); end
                end
            end
        end
        checks++;
        if (nspawn < 100)
            begin errors++; $display("FAIL field_spawns: got %0d spawns want >=100", nspawn); end
    endtask

    task automatic test_pause();
        for (int t = 0; t < 50; t++) begin
            step_a(7, 1'b0, 2);
            checks++;
            if (bus_a.spawn !== 1'b0 || bus_a.obstacle_valid !== exp_v_all() ||
                bus_a.obstacle_x !== exp_x_all() || bus_a.obstacle_y !== exp_y_all() ||
                dut_a.gap_cnt_q !== 9'(m_gap))
                begin errors++; $display("FAIL pause t%0d: spawn=%b v=%b gap=%0d x=%h want 0/%b/%0d x=%h",
                    t, bus_a.spawn, bus_a.obstacle_valid, dut_a.gap_cnt_q, bus_a.obstacle_x,
                    exp_v_all(), m_gap, exp_x_all()); end
        end
        for (int t = 0; t < 40; t++) begin
            step_a((t < 30) ? 5 : 0, 1'b1, 3);
            checks++;
            if (bus_a.spawn !== m_spawn || bus_a.obstacle_valid !== exp_v_all() ||
                bus_a.obstacle_x !== exp_x_all() || bus_a.obstacle_y !== exp_y_all())
                begin errors++; $display("FAIL resume t%0d: spawn=%b v=%b x=%h want %b/%b x=%h",
                    t, bus_a.spawn, bus_a.obstacle_valid, bus_a.obstacle_x,
                    m_spawn, exp_v_all(), exp_x_all()); end
        end
    endtask

    task automatic test_reset_mid();
        rst_a            = 1'b1;
        bus_a.run        = 1'b1;
        bus_a.speed      = 3'd3;
        bus_a.frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a            = 1'b0;
        bus_a.frame_tick = 1'b0;
        model_reset();
        checks++;
        if (bus_a.obstacle_valid !== 10'd0 || bus_a.active_count !== 4'd0 || bus_a.spawn !== 1'b0 ||
            bus_a.obstacle_x !== {10{10'd700, 10'd700}} || dut_a.lfsr_q !== 32'h12345678 ||
            dut_a.gap_cnt_q !== 9'd120)
            begin errors++; $display("FAIL reset_mid: v=%b cnt=%0d spawn=%b lfsr=%h gap=%0d want 0/0/0/12345678/120",
                bus_a.obstacle_valid, bus_a.active_count, bus_a.spawn, dut_a.lfsr_q, dut_a.gap_cnt_q); end
    endtask

    task automatic test_exhaustion();
        for (int n = 1; n <= 663; n++) begin
            step_b(1);
            if (n == 1 || n == 21) begin
                checks++;
                if (bus_b.spawn !== 1'b1 || bus_b.active_count !== ((n == 1) ? 2'd1 : 2'd2))
                    begin errors++; $display("FAIL exh_spawn n%0d: spawn=%b cnt=%0d want 1/%0d",
                        n, bus_b.spawn, bus_b.active_count, (n == 1) ? 1 : 2); end
            end
            if (n > 21 && n < 661) begin
                checks++;
                if (bus_b.spawn !== 1'b0 || bus_b.active_count !== 2'd2)
                    begin errors++; $display("FAIL exh_defer n%0d: spawn=%b cnt=%0d want 0/2",
                        n, bus_b.spawn, bus_b.active_count); end
            end
            if (n == 660) begin
                checks++;
                if (bus_b.obstacle_valid[0] !== 1'b1 || bus_b.obstacle_x[0] !== {10'd0, 10'd1})
                    begin errors++; $display("FAIL exh_edge: v0=%b x0=%h want 1/{0,1}",
                        bus_b.obstacle_valid[0], bus_b.obstacle_x[0]); end
            end
            if (n == 661) begin
                checks++;
                if (bus_b.spawn !== 1'b0 || bus_b.active_count !== 2'd1 ||
                    bus_b.obstacle_valid[0] !== 1'b0 || bus_b.obstacle_x[0] !== {10'd700, 10'd700})
                    begin errors++; $display("FAIL exh_retire: spawn=%b cnt=%0d v0=%b x0=%h want 0/1/0/{700,700}",
                        bus_b.spawn, bus_b.active_count, bus_b.obstacle_valid[0], bus_b.obstacle_x[0]); end
            end
            if (n == 662) begin
                checks++;
                if (bus_b.spawn !== 1'b1 || bus_b.active_count !== 2'd2)
                    begin errors++; $display("FAIL exh_refill: spawn=%b cnt=%0d want 1/2",
                        bus_b.spawn, bus_b.active_count); end
            end
            if (n == 663) begin
                checks++;
                if (bus_b.obstacle_valid[0] !== 1'b1 || bus_b.obstacle_x[0] !== {10'd639, 10'd640})
                    begin errors++; $display("FAIL exh_slot0: v0=%b x0=%h want 1/{639,640}",
                        bus_b.obstacle_valid[0], bus_b.obstacle_x[0]); end
            end
        end
    endtask

    task automatic test_left_clip();
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        step_b(1);
        step_b(1);
        for (int n = 3; n <= 167; n++) begin
            step_b(4);
            if (n == 161) begin
                checks++;
                if (bus_b.obstacle_valid[0] !== 1'b1 || bus_b.obstacle_x[0] !== {10'd3, 10'd23})
                    begin errors++; $display("FAIL clip_pre: v0=%b x0=%h want 1/{3,23}",
                        bus_b.obstacle_valid[0], bus_b.obstacle_x[0]); end
            end
            if (n == 162 || n == 166) begin
                checks++;
                if (bus_b.obstacle_valid[0] !== 1'b1 ||
                    bus_b.obstacle_x[0] !== ((n == 162) ? {10'd0, 10'd19} : {10'd0, 10'd3}))
                    begin errors++; $display("FAIL clip_left n%0d: v0=%b x0=%h want 1/{0,%0d}",
                        n, bus_b.obstacle_valid[0], bus_b.obstacle_x[0], (n == 162) ? 19 : 3); end
            end
            if (n == 167) begin
                checks++;
                if (bus_b.obstacle_valid !== 2'b10 || bus_b.obstacle_x[0] !== {10'd700, 10'd700} ||
                    bus_b.obstacle_x[1] !== {10'd0, 10'd20} || bus_b.active_count !== 2'd1 ||
                    bus_b.spawn !== 1'b0)
                    begin errors++; $display("FAIL clip_retire: v=%b x0=%h x1=%h cnt=%0d spawn=%b want 10/{700,700}/{0,20}/1/0",
                        bus_b.obstacle_valid, bus_b.obstacle_x[0], bus_b.obstacle_x[1],
                        bus_b.active_count, bus_b.spawn); end
            end
        end
    endtask

    initial begin
        bus_a.frame_tick = 1'b0;
        bus_a.run        = 1'b0;
        bus_a.speed      = 3'd0;
        bus_b.frame_tick = 1'b0;
        bus_b.run        = 1'b0;
        bus_b.speed      = 3'd0;
        @(negedge clk);
        test_reset();
        test_first_spawn();
        test_field_ranges();
        test_pause();
        test_reset_mid();
        test_exhaustion();
        test_left_clip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
